// File: rtl/div23_rr_sched_if.sv
// Requester/consumer bundle for the shared divide-by-23 scheduler.
// res_rem exists only when DIV23_SCHED_REM_EN is defined.
interface div23_rr_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]    req_ready;
  logic                res_valid;
  logic                res_ready;
  logic [11:0]         res_q;
  logic [ID_W-1:0]     res_id;
`ifdef DIV23_SCHED_REM_EN
  logic [4:0]          res_rem;
`endif
  logic                busy;

  modport master (
`ifdef DIV23_SCHED_REM_EN
    input  res_rem,
`endif
    output req_valid, req_x, res_ready,
    input  req_ready, res_valid, res_q, res_id, busy
  );

  modport slave (
`ifdef DIV23_SCHED_REM_EN
    output res_rem,
`endif
    input  req_valid, req_x, res_ready,
    output req_ready, res_valid, res_q, res_id, busy
  );
endinterface

// File: rtl/div23_rr_sched.sv
// Round-robin sharing of one two-stage divide-by-23 pipeline.
// Optional remainder output: define DIV23_SCHED_REM_EN.
module div23_rr_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input logic clk,
  input logic rst_n,
  div23_rr_sched_if.slave bus
);

  logic            s1_v;
  logic [15:0]     s1_x;
  logic [ID_W-1:0] s1_id;
  logic            s2_v;
  logic [11:0]     s2_q;
  logic [ID_W-1:0] s2_id;
  logic [ID_W-1:0] rr_ptr;

  logic            s1_adv;
  logic            s2_adv;
  logic            found;
  logic            accept;
  logic [ID_W-1:0] win;
  logic [15:0]     win_x;
  logic [32:0]     prod;
  logic [11:0]     div_q;
  int              idx;

  assign s2_adv = !s2_v | bus.res_ready;
  assign s1_adv = !s1_v | s2_adv;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign accept = rst_n & s1_adv & found;
  assign win_x  = bus.req_x[16*win +: 16];

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[win] = 1'b1;
  end

  // 91181/2^21 over-approximates 1/23 by < 0.015 across 16 bits
  assign prod  = {17'd0, s1_x} * 33'd91181;
  assign div_q = 12'(prod >> 21);

`ifdef DIV23_SCHED_REM_EN
  logic [4:0] s2_rem;
  logic [4:0] div_rem;

  assign div_rem = 5'(s1_x - 16'(div_q) * 16'd23);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s2_rem <= '0;
    else if (s2_adv) s2_rem <= div_rem;
  end

  assign bus.res_rem = s2_rem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      s1_v   <= 1'b0;
      s1_x   <= '0;
      s1_id  <= '0;
    end else begin
      if (accept) rr_ptr <= ID_W'((int'(win) + 1) % N_REQ);
      if (s1_adv) begin
        s1_v <= accept;
        if (accept) begin
          s1_x  <= win_x;
          s1_id <= win;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v  <= 1'b0;
      s2_q  <= '0;
      s2_id <= '0;
    end else if (s2_adv) begin
      s2_v  <= s1_v;
      s2_q  <= div_q;
      s2_id <= s1_id;
    end
  end

  assign bus.res_valid = s2_v;
  assign bus.res_q     = s2_q;
  assign bus.res_id    = s2_id;
  assign bus.busy      = s1_v | s2_v;

endmodule
